// File: rtl/intra_pred_l2_if.sv
// Bus bundle for the level-2 intra prediction stage: level-1 operands, side data, stall
// and the predicted 4x4 block with its qualifiers.
interface intra_pred_l2_if #(
   parameter int bitDepth     = 8,
   parameter int PLA_2_BDEPTH = bitDepth + 3
);
   logic                              bStop;
   logic                              in_valid;
   logic                              in_first;
   logic                              is_planar;
   logic [2:0]                        log2_size;
   logic [19:0]                       weight;
   logic [(bitDepth+1)*16-1:0]        r_r0;
   logic [(bitDepth+1)*16-1:0]        r_r1;
   logic [(bitDepth+4)*16-1:0]        r_plan_0;
   logic [(bitDepth+4)*16-1:0]        r_plan_1;
   logic [PLA_2_BDEPTH*16-1:0]        r_plan_2;
   logic [PLA_2_BDEPTH*16-1:0]        r_plan_3;
   logic [8*bitDepth-1:0]             plan_base;
   logic [16*bitDepth-1:0]            pred;
   logic                              out_valid;
   logic                              tu_last;

   modport master (
      output bStop, in_valid, in_first, is_planar, log2_size, weight,
             r_r0, r_r1, r_plan_0, r_plan_1, r_plan_2, r_plan_3, plan_base,
      input  pred, out_valid, tu_last
   );

   modport slave (
      input  bStop, in_valid, in_first, is_planar, log2_size, weight,
             r_r0, r_r1, r_plan_0, r_plan_1, r_plan_2, r_plan_3, plan_base,
      output pred, out_valid, tu_last
   );
endinterface

// File: rtl/intra_pred_l2.sv
// Second intra prediction stage: weighted angular / planar sums, rounding shift and clip
// to final 4x4 samples, plus per-TU 4x4 block counting. Two stallable register stages.
module intra_pred_l2 #(
   parameter int bitDepth     = 8,
   parameter int PLA_2_BDEPTH = bitDepth + 3
) (
   input  logic           clk,
   input  logic           rst_n,
   intra_pred_l2_if.slave bus
);
   localparam int RW  = bitDepth + 1;
   localparam int P0W = bitDepth + 4;
   localparam int AW  = bitDepth + 7;
   localparam int PW  = bitDepth + 10;
   localparam logic signed [PW:0] MAX_PIX = (PW+1)'((1 << bitDepth) - 1);

   logic signed [PW-1:0]   w_sel [16];
   logic [bitDepth-1:0]    w_pix [16];
   logic signed [PW-1:0]   r_sum [16];
   logic                   r_valid1;
   logic                   r_first1;
   logic                   r_planar1;
   logic [2:0]             r_log2_1;
   logic [16*bitDepth-1:0] r_pred;
   logic                   r_outValid;
   logic                   r_tuLast;
   logic [5:0]             r_cnt;
   logic [5:0]             w_blocks;
   logic [5:0]             w_lastIdx;
   logic [5:0]             w_cntNext;

   for (genvar k = 0; k < 16; k++) begin : g_s1
      localparam int I = k / 4;
      localparam int J = k % 4;
      logic [RW-1:0]           w_r0Raw, w_r1Raw;
      logic [4:0]              w_w;
      logic signed [AW-1:0]    w_r0, w_r1, w_wt0, w_wt1, w_ang;
      logic [bitDepth-1:0]     w_left, w_top;
      logic [P0W-1:0]          w_p0Raw, w_p1Raw;
      logic [PLA_2_BDEPTH-1:0] w_p2Raw, w_p3Raw;
      logic signed [PW-1:0]    w_base, w_p0, w_p1, w_p2, w_p3, w_pla;

      assign w_r0Raw = bus.r_r0[(16-k)*RW-1 -: RW];
      assign w_r1Raw = bus.r_r1[(16-k)*RW-1 -: RW];
      assign w_w     = bus.weight[(4-I)*5-1 -: 5];
      assign w_r0    = {{(AW-RW){w_r0Raw[RW-1]}}, w_r0Raw};
      assign w_r1    = {{(AW-RW){w_r1Raw[RW-1]}}, w_r1Raw};
      assign w_wt1   = {{(AW-5){1'b0}}, w_w};
      assign w_wt0   = AW'(32) - w_wt1;
      assign w_ang   = w_wt0 * w_r0 + w_wt1 * w_r1;

      // plan_base packs top[0..3] in the upper half and left[0..3] in the lower half
      assign w_left  = bus.plan_base[(4-I)*bitDepth-1 -: bitDepth];
      assign w_top   = bus.plan_base[(8-J)*bitDepth-1 -: bitDepth];
      assign w_p0Raw = bus.r_plan_0[(16-k)*P0W-1 -: P0W];
      assign w_p1Raw = bus.r_plan_1[(16-k)*P0W-1 -: P0W];
      assign w_p2Raw = bus.r_plan_2[(16-k)*PLA_2_BDEPTH-1 -: PLA_2_BDEPTH];
      assign w_p3Raw = bus.r_plan_3[(16-k)*PLA_2_BDEPTH-1 -: PLA_2_BDEPTH];
      assign w_base  = (PW'(w_left) + PW'(w_top)) << bus.log2_size;
      assign w_p0    = {{(PW-P0W){w_p0Raw[P0W-1]}}, w_p0Raw};
      assign w_p1    = {{(PW-P0W){w_p1Raw[P0W-1]}}, w_p1Raw};
      assign w_p2    = {{(PW-PLA_2_BDEPTH){w_p2Raw[PLA_2_BDEPTH-1]}}, w_p2Raw};
      assign w_p3    = {{(PW-PLA_2_BDEPTH){w_p3Raw[PLA_2_BDEPTH-1]}}, w_p3Raw};
      assign w_pla   = w_base + ((w_p0 + w_p1) <<< 2) + w_p2 + w_p3;

      assign w_sel[k] = bus.is_planar ? w_pla : {{(PW-AW){w_ang[AW-1]}}, w_ang};
   end

   for (genvar k = 0; k < 16; k++) begin : g_s2
      logic signed [PW:0] w_x, w_rnd, w_v;

      assign w_x   = {r_sum[k][PW-1], r_sum[k]};
      assign w_rnd = r_planar1 ? ((PW+1)'(1) << r_log2_1) : (PW+1)'(16);
      assign w_v   = r_planar1 ? ((w_x + w_rnd) >>> (r_log2_1 + 3'd1))
                               : ((w_x + w_rnd) >>> 5);
      assign w_pix[k] = w_v[PW] ? '0 :
                        (w_v > MAX_PIX) ? MAX_PIX[bitDepth-1:0] : w_v[bitDepth-1:0];
   end

   // A 2^n TU holds 4^(n-2) sub-blocks; a shift of 6 wraps to 0 so the last index becomes 63
   assign w_blocks  = 6'd1 << {r_log2_1 - 3'd2, 1'b0};
   assign w_lastIdx = w_blocks - 6'd1;
   assign w_cntNext = (r_first1 || r_tuLast) ? '0 : r_cnt + 6'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid1   <= 1'b0;
         r_first1   <= 1'b0;
         r_planar1  <= 1'b0;
         r_log2_1   <= '0;
         r_pred     <= '0;
         r_outValid <= 1'b0;
         r_tuLast   <= 1'b0;
         r_cnt      <= '0;
         for (int k = 0; k < 16; k++) r_sum[k] <= '0;
      end else if (!bus.bStop) begin
         r_valid1   <= bus.in_valid;
         r_first1   <= bus.in_valid & bus.in_first;
         r_planar1  <= bus.is_planar;
         r_log2_1   <= bus.log2_size;
         for (int k = 0; k < 16; k++) r_sum[k] <= w_sel[k];
         r_outValid <= r_valid1;
         if (r_valid1) begin
            for (int k = 0; k < 16; k++) r_pred[(15-k)*bitDepth +: bitDepth] <= w_pix[k];
            r_cnt    <= w_cntNext;
            r_tuLast <= (w_cntNext == w_lastIdx);
         end
      end
   end

   assign bus.pred      = r_pred;
   assign bus.out_valid = r_outValid;
   assign bus.tu_last   = r_outValid & r_tuLast;
endmodule
